// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data RAM between the core memory stage (priority) and one auxiliary master.
// A starvation counter forces one aux slot; a tag pipe steers read data back to its owner.
module dmem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {CPU_PRI = 1'b0, EXT_FORCE = 1'b1} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_wait_cnt, w_wait_nxt;
  logic                w_cpu_gnt, w_ext_gnt, w_any_gnt;
  logic                w_push_vld;
  logic [RD_LAT-1:0]   r_tag_vld, r_tag_own;
  logic [ADDR_W-1:0]   r_addr_hold, w_sel_addr;
  logic [DATA_W-1:0]   r_data_hold, w_sel_data;
  logic                w_unused;

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_ext_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      CPU_PRI: begin
        if (cpu_req)      w_cpu_gnt = 1'b1;
        else if (ext_req) w_ext_gnt = 1'b1;
        if (ext_req && !w_ext_gnt && r_wait_cnt == WAIT_LAST) w_state_nxt = EXT_FORCE;
      end
      EXT_FORCE: begin
        w_ext_gnt   = ext_req;
        w_state_nxt = CPU_PRI;
      end
      default: w_state_nxt = CPU_PRI;
    endcase
    // Grants are combinational, so they must be masked explicitly while reset is held.
    if (reset) begin
      w_cpu_gnt = 1'b0;
      w_ext_gnt = 1'b0;
    end
    if (!ext_req || w_ext_gnt)     w_wait_nxt = 8'd0;
    else if (r_wait_cnt != WAIT_LAST) w_wait_nxt = r_wait_cnt + 8'd1;
  end

  assign w_any_gnt  = w_cpu_gnt | w_ext_gnt;
  assign w_sel_addr = w_ext_gnt ? ext_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
  assign w_sel_data = w_ext_gnt ? ext_wdata : cpu_wdata;
  assign w_push_vld = (w_cpu_gnt & ~cpu_we) | (w_ext_gnt & ~ext_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CPU_PRI;
      r_wait_cnt  <= 8'd0;
      r_tag_vld   <= '0;
      r_tag_own   <= '0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_tag_vld[0] <= w_push_vld;
      r_tag_own[0] <= w_ext_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
      if (w_any_gnt) begin
        r_addr_hold <= w_sel_addr;
        r_data_hold <= w_sel_data;
      end
    end
  end

  assign ext_gnt     = w_ext_gnt;
  assign cpu_stall   = cpu_req & ~w_cpu_gnt & ~reset;
  assign mem_wren    = (w_cpu_gnt & cpu_we) | (w_ext_gnt & ext_we);
  assign mem_address = reset ? '0 : (w_any_gnt ? w_sel_addr : r_addr_hold);
  assign mem_data    = reset ? '0 : (w_any_gnt ? w_sel_data : r_data_hold);

  // Owner bit 1 marks an aux read at the tail of the tag pipe.
  assign cpu_rvalid = r_tag_vld[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
  assign ext_rvalid = r_tag_vld[RD_LAT-1] &  r_tag_own[RD_LAT-1];
  assign cpu_rdata  = mem_q;
  assign ext_rdata  = mem_q;

  assign w_unused = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0], ext_addr[31:ADDR_W+2], ext_addr[1:0]};

endmodule
